// File: rtl/schmidl_cox_pkg.sv
// Shared definitions for the metric divider and its iterative core.
// Holds the default operand/result widths and the divider control-FSM
// state type so that the top level and any instantiating block agree.
package schmidl_cox_pkg;

    localparam int DEF_NUM_WIDTH = 32;
    localparam int DEF_DEN_WIDTH = 32;
    localparam int DEF_FRAC_BITS = 16;
    localparam int DEF_OUT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        OUTPUT = 2'd2
    } div_state_t;

endpackage

// File: rtl/udiv_iter_core.sv
// Restoring radix-2 unsigned divider, one quotient bit per clock, MSB first.
// Computes floor((i_num << FRAC_BITS) / i_den) over N = NUM_WIDTH+FRAC_BITS
// iterations.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset (also used as flush)
//   i_start         load operands and begin; sampled every cycle
//   i_num, i_den    dividend / divisor, captured on i_start
//   o_done          one-cycle pulse, the cycle after the last iteration
//   o_quot          N-bit quotient, valid while o_done is high
//   o_divzero       captured divisor was zero
module udiv_iter_core
    import schmidl_cox_pkg::*;
#(
    parameter int NUM_WIDTH = DEF_NUM_WIDTH,
    parameter int DEN_WIDTH = DEF_DEN_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_start,
    input  logic [NUM_WIDTH-1:0]           i_num,
    input  logic [DEN_WIDTH-1:0]           i_den,
    output logic                           o_done,
    output logic [NUM_WIDTH+FRAC_BITS-1:0] o_quot,
    output logic                           o_divzero
);

    localparam int N     = NUM_WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(N + 1);

    logic [DEN_WIDTH:0]   r_rem;
    logic [N-1:0]         r_quot;
    logic [DEN_WIDTH-1:0] r_den;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;

    logic [DEN_WIDTH:0]   w_shift;
    logic [DEN_WIDTH:0]   w_diff;
    logic                 w_ge;

    // r_quot doubles as the dividend shifter: its MSB feeds the remainder
    // and the new quotient bit enters at the LSB. The remainder stays below
    // the divisor, so the shifted value always fits in DEN_WIDTH+1 bits.
    assign w_shift = (r_rem << 1) | {{DEN_WIDTH{1'b0}}, r_quot[N-1]};
    assign w_ge    = (w_shift >= {1'b0, r_den});
    assign w_diff  = w_shift - {1'b0, r_den};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_quot <= N'(i_num) << FRAC_BITS;
                r_den  <= i_den;
                r_cnt  <= CNT_W'(N);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_ge ? w_diff : w_shift;
                r_quot <= {r_quot[N-2:0], w_ge};
                r_cnt  <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done    = r_done;
    assign o_quot    = r_quot;
    assign o_divzero = (r_den == '0);

endmodule

// File: rtl/metric_divider.sv
// Fixed-point metric divider: o_tdata = floor(num * 2^FRAC_BITS / den),
// saturated to all ones (o_tsat=1) on overflow or a zero divisor.
// Joins the dividend and divisor streams, runs the iterative core and
// holds the result in an output register until the consumer takes it.
//
// Ports:
//   clk, reset, clear         clock; synchronous active-high reset / flush
//   s_num_*                   dividend stream (tdata, tlast, tvalid, tready)
//   s_den_*                   divisor stream (tdata, tvalid, tready)
//   o_tdata/o_tsat/o_tlast    quotient, saturation flag, frame marker
//   o_tvalid/o_tready         quotient handshake
//
// state  | meaning
// IDLE   | ready for a num/den pair; both tready high
// DIVIDE | core iterating, inputs blocked
// OUTPUT | result held on o_* until o_tready
module metric_divider
    import schmidl_cox_pkg::*;
#(
    parameter int NUM_WIDTH = DEF_NUM_WIDTH,
    parameter int DEN_WIDTH = DEF_DEN_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [NUM_WIDTH-1:0] s_num_tdata,
    input  logic                 s_num_tlast,
    input  logic                 s_num_tvalid,
    output logic                 s_num_tready,
    input  logic [DEN_WIDTH-1:0] s_den_tdata,
    input  logic                 s_den_tvalid,
    output logic                 s_den_tready,
    output logic [OUT_WIDTH-1:0] o_tdata,
    output logic                 o_tsat,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready
);

    localparam int N = NUM_WIDTH + FRAC_BITS;

    div_state_t           r_state;
    div_state_t           w_next;
    logic [OUT_WIDTH-1:0] r_tdata;
    logic                 r_tsat;
    logic                 r_tlast;

    logic                 w_flush;
    logic                 w_accept;
    logic                 w_ready;
    logic                 w_valid;
    logic                 w_done;
    logic                 w_divzero;
    logic                 w_over;
    logic                 w_sat;
    logic [N-1:0]         w_quot;
    logic [OUT_WIDTH-1:0] w_qfit;

    assign w_flush = reset | clear;

    udiv_iter_core #(
        .NUM_WIDTH (NUM_WIDTH),
        .DEN_WIDTH (DEN_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_core (
        .clk       (clk),
        .reset     (w_flush),
        .i_start   (w_accept),
        .i_num     (s_num_tdata),
        .i_den     (s_den_tdata),
        .o_done    (w_done),
        .o_quot    (w_quot),
        .o_divzero (w_divzero)
    );

    // Quotient bits above the output width mean overflow; a narrower
    // quotient is simply zero-extended.
    generate
        if (N > OUT_WIDTH) begin : g_trunc
            assign w_over = |w_quot[N-1:OUT_WIDTH];
            assign w_qfit = w_quot[OUT_WIDTH-1:0];
        end else begin : g_ext
            assign w_over = 1'b0;
            assign w_qfit = OUT_WIDTH'(w_quot);
        end
    endgenerate

    assign w_sat = w_divzero | w_over;

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_valid  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready  = 1'b1;
                w_accept = s_num_tvalid & s_den_tvalid;
                if (w_accept) begin
                    w_next = DIVIDE;
                end
            end
            DIVIDE: begin
                if (w_done) begin
                    w_next = OUTPUT;
                end
            end
            OUTPUT: begin
                w_valid = 1'b1;
                if (o_tready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state <= IDLE;
            r_tdata <= '0;
            r_tsat  <= 1'b0;
            r_tlast <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_tlast <= s_num_tlast;
            end
            if ((r_state == DIVIDE) && w_done) begin
                r_tsat  <= w_sat;
                r_tdata <= w_sat ? '1 : w_qfit;
            end
        end
    end

    assign s_num_tready = w_ready;
    assign s_den_tready = w_ready;
    assign o_tvalid     = w_valid;
    assign o_tdata      = r_tdata;
    assign o_tsat       = r_tsat;
    assign o_tlast      = r_tlast;

endmodule

// File: tb/tb_metric_divider.sv
`timescale 1ns/1ps
// Self-checking bench for metric_divider at default widths (32/32/16/32).
// Expected results come from plain 64-bit arithmetic on the divide rule.
module tb_metric_divider;

    localparam int LAT = 32 + 16 + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] s_num_tdata = '0;
    logic        s_num_tlast = 1'b0;
    logic        s_num_tvalid = 1'b0;
    logic        s_num_tready;
    logic [31:0] s_den_tdata = '0;
    logic        s_den_tvalid = 1'b0;
    logic        s_den_tready;
    logic [31:0] o_tdata;
    logic        o_tsat;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    metric_divider #(
        .NUM_WIDTH (32),
        .DEN_WIDTH (32),
        .FRAC_BITS (16),
        .OUT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .s_num_tdata  (s_num_tdata),
        .s_num_tlast  (s_num_tlast),
        .s_num_tvalid (s_num_tvalid),
        .s_num_tready (s_num_tready),
        .s_den_tdata  (s_den_tdata),
        .s_den_tvalid (s_den_tvalid),
        .s_den_tready (s_den_tready),
        .o_tdata      (o_tdata),
        .o_tsat       (o_tsat),
        .o_tlast      (o_tlast),
        .o_tvalid     (o_tvalid),
        .o_tready     (o_tready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: floor(num * 65536 / den), saturate above 32 bits or on den==0.
    task automatic model(input logic [31:0] num, input logic [31:0] den,
                         output logic [31:0] q, output logic sat);
        longint unsigned full;
        if (den == 0) begin
            q   = 32'hFFFF_FFFF;
            sat = 1'b1;
        end else begin
            full = (longint'(num) * 65536) / longint'(den);
            if (full > 64'hFFFF_FFFF) begin
                q   = 32'hFFFF_FFFF;
                sat = 1'b1;
            end else begin
                q   = full[31:0];
                sat = 1'b0;
            end
        end
    endtask

    task automatic run_pair(input logic [31:0] num, input logic [31:0] den,
                            input logic last, input int hold, input string tag);
        logic [31:0] eq;
        logic        es;
        int          k;
        logic        rdy_bad;
        logic        hold_bad;
        model(num, den, eq, es);
        s_num_tdata  = num;
        s_den_tdata  = den;
        s_num_tlast  = last;
        s_num_tvalid = 1'b1;
        s_den_tvalid = 1'b1;
        chk({tag, "_rdy"}, {62'd0, s_num_tready, s_den_tready}, 64'd3);
        tick();
        s_num_tvalid = 1'b0;
        s_den_tvalid = 1'b0;
        s_num_tdata  = $urandom;
        s_den_tdata  = $urandom;
        s_num_tlast  = ~last;
        rdy_bad = 1'b0;
        for (k = 1; k <= 100; k++) begin
            if (s_num_tready | s_den_tready) rdy_bad = 1'b1;
            tick();
            if (o_tvalid) break;
        end
        chk({tag, "_lat"}, 64'(k), 64'(LAT));
        chk({tag, "_busy_rdy"}, {63'd0, rdy_bad}, 64'd0);
        chk({tag, "_data"}, {32'd0, o_tdata}, {32'd0, eq});
        chk({tag, "_sat"}, {63'd0, o_tsat}, {63'd0, es});
        chk({tag, "_last"}, {63'd0, o_tlast}, {63'd0, last});
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            s_num_tvalid = 1'b1;
            s_den_tvalid = 1'b1;
            tick();
            if (!o_tvalid || o_tdata !== eq || o_tsat !== es || o_tlast !== last ||
                s_num_tready || s_den_tready) hold_bad = 1'b1;
        end
        s_num_tvalid = 1'b0;
        s_den_tvalid = 1'b0;
        if (hold > 0) chk({tag, "_hold"}, {63'd0, hold_bad}, 64'd0);
        o_tready = 1'b1;
        tick();
        o_tready = 1'b0;
        chk({tag, "_drain"}, {62'd0, o_tvalid, s_num_tready}, 64'd1);
    endtask

    task automatic abort_test(input logic use_clear, input string tag);
        logic seen;
        s_num_tdata  = 32'h0001_2345;
        s_den_tdata  = 32'd3;
        s_num_tlast  = 1'b1;
        s_num_tvalid = 1'b1;
        s_den_tvalid = 1'b1;
        tick();
        s_num_tvalid = 1'b0;
        s_den_tvalid = 1'b0;
        repeat (10) tick();
        if (use_clear) clear = 1'b1; else reset = 1'b1;
        tick();
        clear = 1'b0;
        reset = 1'b0;
        chk({tag, "_rdy"}, {62'd0, s_num_tready, s_den_tready}, 64'd3);
        chk({tag, "_regs"}, {30'd0, o_tvalid, o_tsat, o_tlast, o_tdata}, 64'd0);
        seen = 1'b0;
        o_tready = 1'b1;
        repeat (60) begin
            tick();
            if (o_tvalid) seen = 1'b1;
        end
        o_tready = 1'b0;
        chk({tag, "_nobeat"}, {63'd0, seen}, 64'd0);
        run_pair(32'd50, 32'd5, 1'b0, 0, {tag, "_50_5"});
        chk({tag, "_50_5_val"}, {32'd0, o_tdata}, 64'h0000_0000_000A_0000);
    endtask

    initial begin
        logic        flag;
        logic [31:0] rn, rd;
        repeat (3) tick();
        chk("rst_out", {29'd0, o_tvalid, o_tsat, o_tlast}, 64'd0);
        chk("rst_data", {32'd0, o_tdata}, 64'd0);
        reset = 1'b0;
        chk("rst_rdy", {62'd0, s_num_tready, s_den_tready}, 64'd3);

        run_pair(32'd100, 32'd4, 1'b0, 0, "d100_4");
        run_pair(32'd1, 32'd3, 1'b0, 2, "d1_3");
        run_pair(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "dmax_1");
        run_pair(32'd7, 32'd0, 1'b1, 1, "dzero");
        run_pair(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 0, "dboundary");
        run_pair(32'hFFFF, 32'h1, 1'b0, 0, "dmaxfit");
        run_pair(32'h10000, 32'h1, 1'b0, 0, "dovf1");

        // Dividend valid alone must not be consumed.
        s_num_tdata  = 32'd9;
        s_num_tvalid = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            tick();
            if (!s_num_tready || o_tvalid) flag = 1'b1;
        end
        chk("numonly_wait", {63'd0, flag}, 64'd0);
        run_pair(32'd9, 32'd2, 1'b1, 0, "numonly_pair");
        flag = 1'b0;
        o_tready = 1'b1;
        repeat (60) begin
            tick();
            if (o_tvalid) flag = 1'b1;
        end
        o_tready = 1'b0;
        chk("numonly_single", {63'd0, flag}, 64'd0);

        run_pair(32'd12345, 32'd678, 1'b1, 20, "stall20");

        abort_test(1'b0, "abort_rst");
        abort_test(1'b1, "abort_clr");

        for (int t = 0; t < 30; t++) begin
            rn = $urandom >> $urandom_range(0, 31);
            rd = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) rd = 32'd0;
            run_pair(rn, rd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/metric_divider.md
METRIC_DIVIDER -- requirements
Module: metric_divider

Interface
REQ-001 SHALL have parameter NUM_WIDTH, default 32, dividend width (unsigned).
REQ-002 SHALL have parameter DEN_WIDTH, default 32, divisor width (unsigned).
REQ-003 SHALL have parameter FRAC_BITS, default 16, fractional bits in quotient.
REQ-004 SHALL have parameter OUT_WIDTH, default 32, output quotient width.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port clear  in  1  synchronous flush, same effect as reset.
REQ-007 SHALL have ports s_num_tdata  in  NUM_WIDTH, s_num_tlast  in  1, s_num_tvalid  in  1, s_num_tready  out  1: dividend stream.
REQ-008 SHALL have ports s_den_tdata  in  DEN_WIDTH, s_den_tvalid  in  1, s_den_tready  out  1: divisor stream, fed by the safe-divisor stage.
REQ-009 SHALL have ports o_tdata  out  OUT_WIDTH, o_tsat  out  1, o_tlast  out  1, o_tvalid  out  1, o_tready  in  1: quotient stream.

Function
REQ-010 SHALL compute o_tdata = floor(num * 2^FRAC_BITS / den), unsigned, saturated to 2^OUT_WIDTH-1.
REQ-011 SHALL use an FSM with states IDLE, DIVIDE, OUTPUT.
REQ-012 SHALL drive s_num_tready = s_den_tready = 1 only in IDLE.
REQ-013 SHALL accept a pair only when in IDLE with s_num_tvalid and s_den_tvalid both high, consuming both beats on the same edge; one valid alone SHALL NOT be consumed.
REQ-014 SHALL latch s_num_tlast at acceptance and present it unchanged on o_tlast.
REQ-015 SHALL in DIVIDE perform restoring radix-2 division, one quotient bit per cycle, N = NUM_WIDTH+FRAC_BITS iterations, MSB first.
REQ-016 SHALL use a partial remainder of DEN_WIDTH+1 bits; quotient register N bits.
REQ-017 SHALL move to OUTPUT after the Nth iteration, asserting o_tvalid exactly N+1 cycles after the acceptance edge.
REQ-018 SHALL set o_tsat = 1 and o_tdata = all ones when any bit of the N-bit quotient above OUT_WIDTH-1 is set.
REQ-019 SHALL treat den = 0 as saturation: o_tdata = all ones, o_tsat = 1, same latency.
REQ-020 SHALL hold o_tdata, o_tsat, o_tlast stable while o_tvalid=1 and o_tready=0.
REQ-021 SHALL return to IDLE on the edge where o_tvalid && o_tready; next acceptance no earlier than the following edge.
REQ-022 SHALL ignore input tdata/tlast changes outside the acceptance edge.
REQ-023 SHALL zero-extend when N < OUT_WIDTH.

Reset
REQ-024 SHALL on reset or clear enter IDLE with o_tvalid=0, o_tlast=0, o_tsat=0, o_tdata=0, remainder and quotient registers 0.
REQ-025 SHALL abort any in-progress division or pending output on reset/clear mid-operation, discarding it without emitting a beat.
REQ-026 SHALL assert s_*_tready on the first cycle after reset/clear deasserts.

Structure
REQ-027 SHALL place the FSM state enum and default width constants in shared package schmidl_cox_pkg.
REQ-028 SHALL place the iterative datapath in sub-module udiv_iter_core (start/done/quotient/divzero); metric_divider owns join, FSM and output register.

Verification
REQ-029 SHALL verify num=100, den=4 -> o_tdata=0x00190000, o_tsat=0, o_tvalid 49 cycles after acceptance.
REQ-030 SHALL verify num=1, den=3 -> o_tdata=0x00005555, o_tsat=0; num=0xFFFFFFFF, den=1 -> o_tdata=0xFFFFFFFF, o_tsat=1.
REQ-031 SHALL verify den=0, num=7, tlast=1 -> o_tdata=0xFFFFFFFF, o_tsat=1, o_tlast=1.
REQ-032 SHALL verify s_num_tvalid=1 held 10 cycles with s_den_tvalid=0 -> no acceptance; den valid then -> one acceptance, one output.
REQ-033 SHALL verify o_tready=0 for 20 cycles after o_tvalid -> outputs stable, both s_*_tready=0, no second beat consumed.
REQ-034 SHALL verify reset pulsed 10 cycles after acceptance -> no output beat; next pair 50/5 -> 0x000A0000.
